// File: rtl/shift_register_sipo_ctrl_if.sv
// Signal bundle between the SIPO word-framing controller and the logic that feeds
// it bits and consumes its words.
interface shift_register_sipo_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic          start_i;
  logic          bit_valid_i;
  logic          advance_o;
  logic          sipo_clr_o;
  logic          word_valid_o;
  logic          word_ready_i;
  logic          busy_o;
  logic [CW-1:0] count_o;
  logic          abort_o;
  logic          overrun_o;
  logic          clr_overrun_i;

  modport master (
    output start_i, bit_valid_i, word_ready_i, clr_overrun_i,
    input  advance_o, sipo_clr_o, word_valid_o, busy_o, count_o, abort_o, overrun_o
  );

  modport slave (
    input  start_i, bit_valid_i, word_ready_i, clr_overrun_i,
    output advance_o, sipo_clr_o, word_valid_o, busy_o, count_o, abort_o, overrun_o
  );
endinterface

// File: rtl/shift_register_sipo_ctrl.sv
// Word-framing controller for a SIPO shift register: gates its advance/clear pins,
// counts bits into WIDTH-bit words and holds each finished word for a valid/ready consumer.
module shift_register_sipo_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  shift_register_sipo_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  logic          r_abort;
  logic          r_overrun;

  logic w_in_shift;
  logic w_advance;
  logic w_has_bits;
  logic w_timeout;
  logic w_clr;

  assign w_in_shift = (r_state == ST_SHIFT);
  // start_i takes priority over a coincident bit, which is simply dropped
  assign w_advance  = w_in_shift & bus.bit_valid_i & ~bus.start_i;
  assign w_has_bits = (r_count != '0);
  // fires on the TIMEOUT-th consecutive idle cycle inside a word
  assign w_timeout  = (TIMEOUT != 0) && w_in_shift && !bus.start_i && !bus.bit_valid_i
                      && (r_timer == TMR_LAST);

  always_comb begin
    w_clr = 1'b0;
    case (r_state)
      ST_IDLE:  w_clr = bus.start_i;
      ST_SHIFT: w_clr = bus.start_i | (w_timeout & w_has_bits);
      ST_FULL:  w_clr = bus.word_ready_i & bus.start_i;
      default:  w_clr = 1'b0;
    endcase
  end

  // the SIPO is held clear on every edge while reset is asserted
  assign bus.sipo_clr_o   = ~rst_ni | w_clr;
  assign bus.advance_o    = w_advance;
  assign bus.word_valid_o = (r_state == ST_FULL);
  assign bus.busy_o       = (r_state != ST_IDLE);
  assign bus.count_o      = r_count;
  assign bus.abort_o      = r_abort;
  assign bus.overrun_o    = r_overrun;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_timer   <= '0;
      r_abort   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_abort   <= 1'b0;
      r_overrun <= ((r_state == ST_FULL) & bus.bit_valid_i) | (r_overrun & ~bus.clr_overrun_i);
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_state <= ST_SHIFT;
            r_count <= '0;
            r_timer <= '0;
          end
        end
        ST_SHIFT: begin
          if (bus.start_i) begin
            r_count <= '0;
            r_timer <= '0;
            r_abort <= w_has_bits;
          end else if (bus.bit_valid_i) begin
            r_count <= r_count + CW'(1);
            r_timer <= '0;
            if (r_count == CNT_LAST) begin
              r_state <= ST_FULL;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_timer <= '0;
            r_abort <= w_has_bits;
          end else if (r_timer != TMR_LAST) begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_FULL: begin
          if (bus.word_ready_i) begin
            r_count <= '0;
            r_timer <= '0;
            r_state <= bus.start_i ? ST_SHIFT : ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_register_sipo_ctrl.sv
// Directed vector bench for the SIPO word-framing controller, with a small SIPO model
// driven by the controller's advance/clear pins.
module tb_shift_register_sipo_ctrl;
  logic       clk;
  logic       rst_n;
  logic       bit_d;
  logic [7:0] sipo;
  int         checks;
  int         errors;

  shift_register_sipo_ctrl_if #(.WIDTH(8)) sif ();

  shift_register_sipo_ctrl #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream SIPO: synchronous clear, MSB = first bit
  always_ff @(posedge clk) begin
    if (sif.sipo_clr_o) sipo <= 8'h00;
    else if (sif.advance_o) sipo <= {sipo[6:0], bit_d};
  end

  typedef struct {
    logic       st, bv, b, rdy, clr;
    logic       adv, sclr, wv, bsy;
    int         cnt;
    logic       ab, ov;
    logic [7:0] sv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, bv, b, rdy, clr,
                              input logic adv, sclr, wv, bsy, input int cnt,
                              input logic ab, ov, input logic [7:0] sv);
    vec_t v;
    v = '{st, bv, b, rdy, clr, adv, sclr, wv, bsy, cnt, ab, ov, sv};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic st, bv, b, rdy, clr);
    sif.start_i       = st;
    sif.bit_valid_i   = bv;
    bit_d             = b;
    sif.word_ready_i  = rdy;
    sif.clr_overrun_i = clr;
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("advance",    idx, 32'(sif.advance_o),    32'(v.adv));
    chk("sipo_clr",   idx, 32'(sif.sipo_clr_o),   32'(v.sclr));
    chk("word_valid", idx, 32'(sif.word_valid_o), 32'(v.wv));
    chk("busy",       idx, 32'(sif.busy_o),       32'(v.bsy));
    chk("count",      idx, 32'(sif.count_o),      32'(v.cnt));
    chk("abort",      idx, 32'(sif.abort_o),      32'(v.ab));
    chk("overrun",    idx, 32'(sif.overrun_o),    32'(v.ov));
    chk("sipo_value", idx, 32'(sipo),             32'(v.sv));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0);

    //  st bv b rdy clr | adv clr wv bsy cnt ab ov sipo
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,8'h00);
    add(1,0,0,0,0, 0,1,0,0,0, 0,0,8'h00);
    // word 0xA5
    add(0,1,1,0,0, 1,0,0,1,0, 0,0,8'h00);
    add(0,1,0,0,0, 1,0,0,1,1, 0,0,8'h01);
    add(0,1,1,0,0, 1,0,0,1,2, 0,0,8'h02);
    add(0,1,0,0,0, 1,0,0,1,3, 0,0,8'h05);
    add(0,1,0,0,0, 1,0,0,1,4, 0,0,8'h0A);
    add(0,1,1,0,0, 1,0,0,1,5, 0,0,8'h14);
    add(0,1,0,0,0, 1,0,0,1,6, 0,0,8'h29);
    add(0,1,1,0,0, 1,0,0,1,7, 0,0,8'h52);
    // backpressure, overrun set, set-beats-clear, then clear and accept
    add(0,0,0,0,0, 0,0,1,1,8, 0,0,8'hA5);
    add(0,1,1,0,0, 0,0,1,1,8, 0,0,8'hA5);
    add(0,0,0,0,0, 0,0,1,1,8, 0,1,8'hA5);
    add(0,1,0,0,1, 0,0,1,1,8, 0,1,8'hA5);
    add(0,0,0,0,1, 0,0,1,1,8, 0,1,8'hA5);
    add(0,0,0,1,0, 0,0,1,1,8, 0,0,8'hA5);
    add(0,1,1,0,0, 0,0,0,0,0, 0,0,8'hA5);
    // timeout abort after 3 bits and 4 idle cycles
    add(1,0,0,0,0, 0,1,0,0,0, 0,0,8'hA5);
    add(0,1,1,0,0, 1,0,0,1,0, 0,0,8'h00);
    add(0,1,1,0,0, 1,0,0,1,1, 0,0,8'h01);
    add(0,1,1,0,0, 1,0,0,1,2, 0,0,8'h03);
    add(0,0,0,0,0, 0,0,0,1,3, 0,0,8'h07);
    add(0,0,0,0,0, 0,0,0,1,3, 0,0,8'h07);
    add(0,0,0,0,0, 0,0,0,1,3, 0,0,8'h07);
    add(0,0,0,0,0, 0,1,0,1,3, 0,0,8'h07);
    add(0,0,0,0,0, 0,0,0,0,0, 1,0,8'h00);
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,8'h00);
    // gaps of 3 idle cycles never abort
    add(1,0,0,0,0, 0,1,0,0,0, 0,0,8'h00);
    add(0,1,1,0,0, 1,0,0,1,0, 0,0,8'h00);
    add(0,0,0,0,0, 0,0,0,1,1, 0,0,8'h01);
    add(0,0,0,0,0, 0,0,0,1,1, 0,0,8'h01);
    add(0,0,0,0,0, 0,0,0,1,1, 0,0,8'h01);
    add(0,1,0,0,0, 1,0,0,1,1, 0,0,8'h01);
    add(0,0,0,0,0, 0,0,0,1,2, 0,0,8'h02);
    add(0,0,0,0,0, 0,0,0,1,2, 0,0,8'h02);
    add(0,0,0,0,0, 0,0,0,1,2, 0,0,8'h02);
    add(0,1,1,0,0, 1,0,0,1,2, 0,0,8'h02);
    add(0,0,0,0,0, 0,0,0,1,3, 0,0,8'h05);
    // restart with a coincident bit: bit dropped, abort pulses, then word 0x3C
    add(1,1,1,0,0, 0,1,0,1,3, 0,0,8'h05);
    add(0,1,0,0,0, 1,0,0,1,0, 1,0,8'h00);
    add(0,1,0,0,0, 1,0,0,1,1, 0,0,8'h00);
    add(0,1,1,0,0, 1,0,0,1,2, 0,0,8'h00);
    add(0,1,1,0,0, 1,0,0,1,3, 0,0,8'h01);
    add(0,1,1,0,0, 1,0,0,1,4, 0,0,8'h03);
    add(0,1,1,0,0, 1,0,0,1,5, 0,0,8'h07);
    add(0,1,0,0,0, 1,0,0,1,6, 0,0,8'h0F);
    add(0,1,0,0,0, 1,0,0,1,7, 0,0,8'h1E);
    // back-to-back: ready + start in FULL, ready then held high
    add(1,0,0,1,0, 0,1,1,1,8, 0,0,8'h3C);
    add(0,1,1,1,0, 1,0,0,1,0, 0,0,8'h00);
    add(0,1,0,1,0, 1,0,0,1,1, 0,0,8'h01);
    add(0,1,1,1,0, 1,0,0,1,2, 0,0,8'h02);
    add(0,1,0,1,0, 1,0,0,1,3, 0,0,8'h05);
    add(0,1,0,1,0, 1,0,0,1,4, 0,0,8'h0A);
    add(0,1,1,1,0, 1,0,0,1,5, 0,0,8'h14);
    add(0,1,0,1,0, 1,0,0,1,6, 0,0,8'h29);
    add(0,1,1,1,0, 1,0,0,1,7, 0,0,8'h52);
    add(0,0,0,1,0, 0,0,1,1,8, 0,0,8'hA5);
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,8'hA5);
    // empty word times out silently
    add(1,0,0,0,0, 0,1,0,0,0, 0,0,8'hA5);
    add(0,0,0,0,0, 0,0,0,1,0, 0,0,8'h00);
    add(0,0,0,0,0, 0,0,0,1,0, 0,0,8'h00);
    add(0,0,0,0,0, 0,0,0,1,0, 0,0,8'h00);
    add(0,0,0,0,0, 0,0,0,1,0, 0,0,8'h00);
    add(0,0,0,0,0, 0,0,0,0,0, 0,0,8'h00);

    // reset state
    @(negedge clk);
    #1;
    chk("rst_sipo_clr",   -1, 32'(sif.sipo_clr_o),   32'd1);
    chk("rst_busy",       -1, 32'(sif.busy_o),       32'd0);
    chk("rst_word_valid", -1, 32'(sif.word_valid_o), 32'd0);
    chk("rst_count",      -1, 32'(sif.count_o),      32'd0);
    chk("rst_sipo_value", -1, 32'(sipo),             32'd0);
    $display("reset: clr=%0b busy=%0b", sif.sipo_clr_o, sif.busy_o);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].bv, vecs[i].b, vecs[i].rdy, vecs[i].clr);
      #1;
      chk_all(i, vecs[i]);
      $display("step %0d: st=%0b bv=%0b rdy=%0b adv=%0b clr=%0b wv=%0b busy=%0b cnt=%0d ab=%0b ov=%0b sipo=%02h",
               i, vecs[i].st, vecs[i].bv, vecs[i].rdy, sif.advance_o, sif.sipo_clr_o,
               sif.word_valid_o, sif.busy_o, sif.count_o, sif.abort_o, sif.overrun_o, sipo);
    end

    // asynchronous reset in the middle of a word
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1, 1, 0, 0);
    end
    @(negedge clk);
    #1;
    chk("mid_count", 100, 32'(sif.count_o), 32'd4);
    chk("mid_busy",  100, 32'(sif.busy_o),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",     101, 32'(sif.busy_o),     32'd0);
    chk("arst_count",    101, 32'(sif.count_o),    32'd0);
    chk("arst_advance",  101, 32'(sif.advance_o),  32'd0);
    chk("arst_sipo_clr", 101, 32'(sif.sipo_clr_o), 32'd1);
    $display("async reset: busy=%0b cnt=%0d clr=%0b", sif.busy_o, sif.count_o, sif.sipo_clr_o);
    @(posedge clk);
    #1;
    chk("arst_sipo_value", 102, 32'(sipo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1, 1, 0, 0);
      #1;
      chk("post_rst_advance", 103 + i, 32'(sif.advance_o), 32'd0);
      chk("post_rst_busy",    103 + i, 32'(sif.busy_o),    32'd0);
      chk("post_rst_sipo",    103 + i, 32'(sipo),          32'd0);
      $display("post-reset bit %0d: adv=%0b busy=%0b", i, sif.advance_o, sif.busy_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
